// File: rtl/ensemble_vote_combiner.sv
// Three-lane majority voter: per-lane FIFOs align classifier results, one voted word per sample.
// Optional VOTE_STATS_EN enables the sample / split counters; otherwise they are tied to zero.
module ensemble_vote_combiner #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int LABEL_WIDTH = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIE_LANE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  err_tlast_mismatch,
  output logic [31:0]           stat_samples,
  output logic [31:0]           stat_splits
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = LABEL_WIDTH + 1;
  localparam logic [AW:0] FULL_GAP = {1'b1, {AW{1'b0}}};

  logic [2:0]             in_vld;
  logic [2:0]             in_last;
  logic [2:0]             in_rdy;
  logic [2:0]             push;
  logic [2:0]             head_vld;
  logic [LABEL_WIDTH-1:0] in_lab [3];
  logic [EW-1:0]          head   [3];
  logic                   pop;

  assign in_vld    = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_last   = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
  assign in_lab[0] = s_axis_tdata_0[LABEL_WIDTH-1:0];
  assign in_lab[1] = s_axis_tdata_1[LABEL_WIDTH-1:0];
  assign in_lab[2] = s_axis_tdata_2[LABEL_WIDTH-1:0];

  assign s_axis_tready_0 = in_rdy[0];
  assign s_axis_tready_1 = in_rdy[1];
  assign s_axis_tready_2 = in_rdy[2];

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                           s_axis_tdata_0[DATA_WIDTH-1:LABEL_WIDTH],
                           s_axis_tdata_1[DATA_WIDTH-1:LABEL_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:LABEL_WIDTH]};

  // Per-lane FIFO; ready is the registered "not full" of the post-update occupancy
  for (genvar g = 0; g < 3; g++) begin : g_lane
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          rdy_q, rdy_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    assign push[g]     = in_vld[g] && rdy_q;
    assign head_vld[g] = (wptr_q != rptr_q);
    assign head[g]     = mem_q[rptr_q[AW-1:0]];
    assign in_rdy[g]   = rdy_q;

    always_comb begin
      wptr_d = wptr_q + {{AW{1'b0}}, push[g]};
      rptr_d = rptr_q + {{AW{1'b0}}, pop};
      rdy_d  = ((wptr_d - rptr_d) != FULL_GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        rdy_q  <= 1'b0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        rdy_q  <= rdy_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wptr_q[AW-1:0]] <= {in_last[g], in_lab[g]};
    end
  end

  logic [LABEL_WIDTH-1:0] lab [3];
  logic [2:0]             lst;
  logic [LABEL_WIDTH-1:0] win;
  logic [2:0]             agree;
  logic                   unan;
  logic                   tie;
  logic [DATA_WIDTH-1:0]  word;

  assign lab[0] = head[0][LABEL_WIDTH-1:0];
  assign lab[1] = head[1][LABEL_WIDTH-1:0];
  assign lab[2] = head[2][LABEL_WIDTH-1:0];
  assign lst    = {head[2][EW-1], head[1][EW-1], head[0][EW-1]};

  // Vote: any matching pair wins; a three-way split falls back to TIE_LANE
  always_comb begin
    tie = 1'b0;
    if (lab[0] == lab[1] || lab[0] == lab[2]) begin
      win = lab[0];
    end else if (lab[1] == lab[2]) begin
      win = lab[1];
    end else begin
      win = lab[TIE_LANE];
      tie = 1'b1;
    end
    for (int k = 0; k < 3; k++) agree[k] = (lab[k] == win);
    unan = &agree;
    word = '0;
    word[LABEL_WIDTH+4:0] = {tie, unan, agree, win};
  end

  logic                  vld_q, vld_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign pop = (&head_vld) && (!vld_q || m_axis_tready);

  always_comb begin
    vld_d  = vld_q && !m_axis_tready;
    data_d = data_q;
    last_d = last_q;
    err_d  = err_q;
    if (pop) begin
      vld_d  = 1'b1;
      data_d = word;
      last_d = lst[0];
      err_d  = err_q || !((lst == 3'b000) || (lst == 3'b111));
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign m_axis_tvalid      = vld_q;
  assign m_axis_tdata       = data_q;
  assign m_axis_tlast       = last_q;
  assign m_axis_tkeep       = {KEEP_WIDTH{vld_q}};
  assign err_tlast_mismatch = err_q;

`ifdef VOTE_STATS_EN
  logic [31:0] samples_q, samples_d;
  logic [31:0] splits_q, splits_d;

  always_comb begin
    samples_d = samples_q + {31'd0, pop};
    splits_d  = splits_q + {31'd0, pop && !unan};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples_q <= '0;
      splits_q  <= '0;
    end else begin
      samples_q <= samples_d;
      splits_q  <= splits_d;
    end
  end

  assign stat_samples = samples_q;
  assign stat_splits  = splits_q;
`else
  assign stat_samples = 32'd0;
  assign stat_splits  = 32'd0;
`endif

endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// Scoreboard bench for ensemble_vote_combiner (TIE_LANE=2): per-lane drivers, output monitor.
module tb_ensemble_vote_combiner;

  localparam int TIE = 2;
`ifdef VOTE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [2:0][7:0] lab;
    logic [2:0]      lst;
  } smp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata_a [3];
  logic [3:0]  tkeep_a [3];
  logic        tvalid_a [3];
  logic        tready_a [3];
  logic        tlast_a [3];
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        err_tlast_mismatch;
  logic [31:0] stat_samples;
  logic [31:0] stat_splits;

  int   n_cmp = 0;
  int   n_err = 0;
  smp_t samples [$];
  exp_t exp_q [$];
  int   idx [3];
  int   dly [3];
  int   cyc;

  always #5 clk = ~clk;

  ensemble_vote_combiner #(.TIE_LANE(TIE)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_0(tdata_a[0]), .s_axis_tkeep_0(tkeep_a[0]), .s_axis_tvalid_0(tvalid_a[0]),
    .s_axis_tready_0(tready_a[0]), .s_axis_tlast_0(tlast_a[0]),
    .s_axis_tdata_1(tdata_a[1]), .s_axis_tkeep_1(tkeep_a[1]), .s_axis_tvalid_1(tvalid_a[1]),
    .s_axis_tready_1(tready_a[1]), .s_axis_tlast_1(tlast_a[1]),
    .s_axis_tdata_2(tdata_a[2]), .s_axis_tkeep_2(tkeep_a[2]), .s_axis_tvalid_2(tvalid_a[2]),
    .s_axis_tready_2(tready_a[2]), .s_axis_tlast_2(tlast_a[2]),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .err_tlast_mismatch(err_tlast_mismatch),
    .stat_samples(stat_samples), .stat_splits(stat_splits)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference vote by counting occurrences of each label
  function automatic exp_t model(input smp_t s);
    exp_t       e;
    logic [7:0] w;
    logic [2:0] mask;
    bit         found;
    int         cnt;
    found = 1'b0;
    w = s.lab[TIE];
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      for (int j = 0; j < 3; j++) if (s.lab[j] == s.lab[i]) cnt++;
      if (cnt >= 2 && !found) begin
        w = s.lab[i];
        found = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) mask[k] = (s.lab[k] == w);
    e.data = {19'd0, !found, (mask == 3'b111), mask, w};
    e.last = s.lst[0];
    return e;
  endfunction

  task automatic add_sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [2:0] l);
    smp_t s;
    s.lab = {c, b, a};
    s.lst = l;
    samples.push_back(s);
    exp_q.push_back(model(s));
  endtask

  task automatic add_sample_lit(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic [2:0] l, input logic [31:0] word);
    smp_t s;
    exp_t e;
    s.lab = {c, b, a};
    s.lst = l;
    e.data = word;
    e.last = l[0];
    samples.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic run_lanes(input int max_cycles, input bit rnd);
    bit v [3];
    bit hs [3];
    for (int c = 0; c < max_cycles; c++) begin
      if (idx[0] >= samples.size() && idx[1] >= samples.size() && idx[2] >= samples.size()) break;
      @(negedge clk);
      if (rnd) m_axis_tready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        v[k] = (idx[k] < samples.size()) && (cyc >= dly[k]);
        if (rnd && ($urandom_range(0, 3) == 0)) v[k] = 1'b0;
        tvalid_a[k] = v[k];
        if (idx[k] < samples.size()) begin
          tdata_a[k] = {24'hABCDEF, samples[idx[k]].lab[k]};
          tlast_a[k] = samples[idx[k]].lst[k];
        end
        hs[k] = v[k] && tready_a[k];
      end
      if (dly[2] > 0 && cyc == dly[2]) begin
        chk("skew_no_early_out", m_axis_tvalid, 1'b0);
        chk("skew_lane0_ready", tready_a[0], 1'b1);
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) if (hs[k]) idx[k]++;
      cyc++;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) tvalid_a[k] = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    samples.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      idx[k] = 0;
      tvalid_a[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Output monitor, sampled just before each rising edge
  logic        hold_prev = 1'b0;
  logic [32:0] prev_word;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (m_axis_tvalid) begin
          chk("tkeep_ones", m_axis_tkeep, 4'hF);
          if (hold_prev) chk("held_word", {m_axis_tlast, m_axis_tdata}, prev_word);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", {m_axis_tlast, m_axis_tdata}, 33'h1DEADBEEF);
          end else begin
            e = exp_q.pop_front();
            chk("vote_data", m_axis_tdata, e.data);
            chk("vote_last", m_axis_tlast, e.last);
          end
        end
        hold_prev = m_axis_tvalid && !m_axis_tready;
        prev_word = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base [3];
    for (int k = 0; k < 3; k++) begin
      tdata_a[k] = '0; tkeep_a[k] = 4'hF; tvalid_a[k] = 1'b0; tlast_a[k] = 1'b0;
      idx[k] = 0; dly[k] = 0;
    end
    cyc = 0;
    m_axis_tready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("rst_tready", tready_a[k], 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tkeep", m_axis_tkeep, 4'h0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_err", err_tlast_mismatch, 1'b0);
    chk("rst_samples", stat_samples, 32'd0);
    chk("rst_splits", stat_splits, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("post_rst_tready", tready_a[k], 1'b1);

    // Unanimous 3,3,3 with latency check
    @(negedge clk);
    add_sample_lit(8'd3, 8'd3, 8'd3, 3'b000, 32'h0000_0F03);
    for (int k = 0; k < 3; k++) begin
      tvalid_a[k] = 1'b1; tdata_a[k] = 32'h0000_0003; tlast_a[k] = 1'b0;
      idx[k] = 1;
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) tvalid_a[k] = 1'b0;
    chk("lat_edge1_vld", m_axis_tvalid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_edge2_vld", m_axis_tvalid, 1'b1);
    chk("unan_word", m_axis_tdata[12:0], 13'h0F03);
    drain(20);

    // Pair and three-way split
    add_sample_lit(8'd5, 8'd5, 8'd9, 3'b000, 32'h0000_0305);
    add_sample_lit(8'd1, 8'd2, 8'd3, 3'b000, 32'h0000_1403);
    add_sample_lit(8'd4, 8'd7, 8'd7, 3'b111, 32'h0000_0607);
    run_lanes(100, 1'b0);
    drain(50);

    // Skew: lane 2 starts 20 cycles late
    cyc = 0;
    dly[2] = 20;
    for (int i = 0; i < 6; i++)
      add_sample(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 3'b000);
    run_lanes(200, 1'b0);
    dly[2] = 0;
    drain(50);

    // Backpressure: 12 samples, sink stalled for 30 cycles
    @(negedge clk);
    m_axis_tready = 1'b0;
    cyc = 0;
    for (int k = 0; k < 3; k++) base[k] = idx[k];
    for (int i = 0; i < 12; i++) add_sample(8'(i), 8'(i), 8'(i + 1), 3'b000);
    run_lanes(30, 1'b0);
    // One sample is already in the output register; the FIFO holds FIFO_DEPTH more
    for (int k = 0; k < 3; k++) begin
      chk("bp_accepted", idx[k] - base[k], 9);
      chk("bp_tready_low", tready_a[k], 1'b0);
    end
    chk("bp_out_vld", m_axis_tvalid, 1'b1);
    m_axis_tready = 1'b1;
    run_lanes(200, 1'b0);
    drain(100);

    // Random labels, lane stalls and sink backpressure
    for (int i = 0; i < 40; i++) begin
      logic l;
      l = 1'($urandom_range(0, 1));
      add_sample(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                 {l, l, l});
    end
    run_lanes(2000, 1'b1);
    @(negedge clk);
    m_axis_tready = 1'b1;
    drain(200);
    chk("err_clean", err_tlast_mismatch, 1'b0);

    // tlast mismatch is sticky
    add_sample_lit(8'd2, 8'd2, 8'd2, 3'b101, 32'h0000_0F02);
    run_lanes(50, 1'b0);
    drain(20);
    @(negedge clk);
    chk("err_set", err_tlast_mismatch, 1'b1);
    add_sample(8'd8, 8'd8, 8'd1, 3'b000);
    run_lanes(50, 1'b0);
    drain(20);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_tlast_mismatch, 1'b1);

    // Statistics: 4 votes, 2 of them split
    do_reset();
    chk("err_cleared_by_rst", err_tlast_mismatch, 1'b0);
    add_sample(8'd7, 8'd7, 8'd7, 3'b000);
    add_sample(8'd1, 8'd1, 8'd2, 3'b000);
    add_sample(8'd4, 8'd5, 8'd6, 3'b000);
    add_sample(8'd9, 8'd9, 8'd9, 3'b000);
    run_lanes(100, 1'b0);
    drain(50);
    @(negedge clk);
    chk("stat_samples", stat_samples, STATS ? 32'd4 : 32'd0);
    chk("stat_splits", stat_splits, STATS ? 32'd2 : 32'd0);

    // Reset mid-stream with a held output and occupied FIFOs
    m_axis_tready = 1'b0;
    add_sample(8'd1, 8'd2, 8'd3, 3'b010);
    add_sample(8'd3, 8'd3, 8'd1, 3'b000);
    add_sample(8'd6, 8'd0, 8'd6, 3'b000);
    run_lanes(6, 1'b0);
    chk("mid_vld_pre", m_axis_tvalid, 1'b1);
    chk("mid_err_pre", err_tlast_mismatch, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", m_axis_tvalid, 1'b0);
    chk("mid_rst_data", m_axis_tdata, 32'd0);
    chk("mid_rst_last", m_axis_tlast, 1'b0);
    chk("mid_rst_keep", m_axis_tkeep, 4'h0);
    chk("mid_rst_err", err_tlast_mismatch, 1'b0);
    chk("mid_rst_samples", stat_samples, 32'd0);
    chk("mid_rst_splits", stat_splits, 32'd0);
    for (int k = 0; k < 3; k++) chk("mid_rst_tready", tready_a[k], 1'b0);
    samples.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++) idx[k] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("rel_tready", tready_a[k], 1'b1);
    repeat (4) @(negedge clk);
    chk("rel_no_output", m_axis_tvalid, 1'b0);

    // Still operational after the reset
    add_sample(8'd6, 8'd6, 8'd1, 3'b111);
    run_lanes(50, 1'b0);
    drain(20);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
